router_sync_n: RTL and testbench

ROUTER_SYNC_N -- requirements
Module: router_sync_n

---
 rtl/router_sync_n_if.sv | 42 ++++
 rtl/router_sync_n.sv | 109 ++++++++++
 tb/tb_router_sync_n.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/router_sync_n_if.sv
// Bundle of the router synchroniser's data-path and handshake signals.
// The sts_clr/timeout_sts pair exists only when ROUTER_SYNC_STATUS_EN is defined.
interface router_sync_n_if #(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned ADDR_W = 2
) ();
    logic              detect_add;
    logic [ADDR_W-1:0] data_in;
    logic              write_enb_reg;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] read_enb;
    logic [NUM_CH-1:0] write_enb;
    logic [NUM_CH-1:0] vld_out;
    logic              fifo_full;
    logic [NUM_CH-1:0] soft_reset;
    logic              addr_err;
`ifdef ROUTER_SYNC_STATUS_EN
    logic              sts_clr;
    logic [NUM_CH-1:0] timeout_sts;

    modport master (
        output detect_add, data_in, write_enb_reg, full, empty, read_enb, sts_clr,
        input  write_enb, vld_out, fifo_full, soft_reset, addr_err, timeout_sts
    );

    modport slave (
        input  detect_add, data_in, write_enb_reg, full, empty, read_enb, sts_clr,
        output write_enb, vld_out, fifo_full, soft_reset, addr_err, timeout_sts
    );
`else
    modport master (
        output detect_add, data_in, write_enb_reg, full, empty, read_enb,
        input  write_enb, vld_out, fifo_full, soft_reset, addr_err
    );

    modport slave (
        input  detect_add, data_in, write_enb_reg, full, empty, read_enb,
        output write_enb, vld_out, fifo_full, soft_reset, addr_err
    );
`endif
endinterface

// File: rtl/router_sync_n.sv
// Router synchroniser: latches destination address, steers FIFO writes and flushes stale FIFOs.
// Optional sticky timeout status is enabled by defining ROUTER_SYNC_STATUS_EN.
module router_sync_n #(
    parameter int unsigned NUM_CH  = 3,
    parameter int unsigned ADDR_W  = 2,
    parameter int unsigned TIMEOUT = 30,
    parameter int unsigned CNT_W   = 6
) (
    input logic             clock,
    input logic             resetn,
    router_sync_n_if.slave  bus
);

    if (NUM_CH < 2 || NUM_CH > 8) begin : g_bad_num_ch
        $error("router_sync_n: NUM_CH must be within 2..8");
    end
    if ((longint'(1) << ADDR_W) < longint'(NUM_CH)) begin : g_bad_addr_w
        $error("router_sync_n: ADDR_W too narrow for NUM_CH");
    end
    if (TIMEOUT < 2 || longint'(TIMEOUT) > (longint'(1) << CNT_W)) begin : g_bad_timeout
        $error("router_sync_n: TIMEOUT must be within 2..2**CNT_W");
    end

    localparam logic [ADDR_W:0]  NumChW  = (ADDR_W + 1)'(NUM_CH);
    localparam logic [CNT_W-1:0] TermCnt = CNT_W'(TIMEOUT - 1);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              addr_err_q, addr_err_d;
    logic [NUM_CH-1:0] sel;
    logic [NUM_CH-1:0] vld;
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] soft_reset_q, soft_reset_d;

    always_comb begin
        addr_d     = addr_q;
        addr_err_d = addr_err_q;
        if (bus.detect_add) begin
            addr_d     = bus.data_in;
            addr_err_d = ({1'b0, bus.data_in} >= NumChW);
        end
    end

    // An out-of-range address matches no channel, so writes and full both read as zero.
    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            sel[i] = (addr_q == ADDR_W'(i));
        end
    end

    assign vld           = ~bus.empty;
    assign bus.vld_out   = vld;
    assign bus.write_enb = bus.write_enb_reg ? sel : '0;
    assign bus.fifo_full = |(bus.full & sel);
    assign bus.addr_err  = addr_err_q;
    assign bus.soft_reset = soft_reset_q;

    // Per-channel stall watchdog; terminal count fires the flush and restarts the window.
    always_comb begin
        soft_reset_d = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = '0;
            if (vld[i] && !bus.read_enb[i]) begin
                if (cnt_q[i] == TermCnt) begin
                    soft_reset_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            addr_q       <= '0;
            addr_err_q   <= 1'b0;
            soft_reset_q <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            addr_q       <= addr_d;
            addr_err_q   <= addr_err_d;
            soft_reset_q <= soft_reset_d;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef ROUTER_SYNC_STATUS_EN
    logic [NUM_CH-1:0] sts_q, sts_d;

    // A new timeout outranks a coincident clear.
    assign sts_d = (sts_q & ~{NUM_CH{bus.sts_clr}}) | soft_reset_d;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sts_q <= '0;
        end else begin
            sts_q <= sts_d;
        end
    end

    assign bus.timeout_sts = sts_q;
`endif

endmodule

// File: tb/tb_router_sync_n.sv
// Directed self-checking bench for router_sync_n (default parameters).
module tb_router_sync_n;

    logic clock = 1'b0;
    logic resetn;
    int   checks = 0;
    int   errors = 0;

    router_sync_n_if #(.NUM_CH(3), .ADDR_W(2)) bus ();

    router_sync_n #(
        .NUM_CH (3),
        .ADDR_W (2),
        .TIMEOUT(30),
        .CNT_W  (6)
    ) u_dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Advance n edges, requiring no flush pulse after any of them.
    task automatic quiet(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            step();
            chk(tag, 32'(bus.soft_reset), 32'h0);
        end
    endtask

    initial begin
        resetn            = 1'b0;
        bus.detect_add    = 1'b0;
        bus.data_in       = '0;
        bus.write_enb_reg = 1'b0;
        bus.full          = 3'b000;
        bus.empty         = 3'b111;
        bus.read_enb      = 3'b000;
`ifdef ROUTER_SYNC_STATUS_EN
        bus.sts_clr       = 1'b0;
`endif
        #1;
        chk("rst_write_enb", 32'(bus.write_enb), 32'h0);
        chk("rst_soft_reset", 32'(bus.soft_reset), 32'h0);
        chk("rst_addr_err", 32'(bus.addr_err), 32'h0);
        chk("rst_vld_out", 32'(bus.vld_out), 32'h0);
        bus.write_enb_reg = 1'b1;
        bus.full          = 3'b001;
        #1;
        chk("rst_sel0_we", 32'(bus.write_enb), 32'h1);
        chk("rst_sel0_full", 32'(bus.fifo_full), 32'h1);
        bus.full = 3'b110;
        #1;
        chk("rst_sel0_notfull", 32'(bus.fifo_full), 32'h0);

        step();
        resetn = 1'b1;

        // Header and write in the same cycle still use address 0.
        bus.detect_add = 1'b1;
        bus.data_in    = 2'd1;
        bus.full       = 3'b010;
        #1;
        chk("coinc_we_old_addr", 32'(bus.write_enb), 32'h1);
        chk("coinc_full_old_addr", 32'(bus.fifo_full), 32'h0);
        step();
        bus.detect_add = 1'b0;
        chk("addr1_we", 32'(bus.write_enb), 32'h2);
        chk("addr1_full", 32'(bus.fifo_full), 32'h1);
        bus.full = 3'b101;
        #1;
        chk("addr1_notfull", 32'(bus.fifo_full), 32'h0);

        bus.detect_add = 1'b1;
        bus.data_in    = 2'd3;
        bus.full       = 3'b111;
        step();
        bus.detect_add = 1'b0;
        chk("bad_addr_err", 32'(bus.addr_err), 32'h1);
        chk("bad_addr_we", 32'(bus.write_enb), 32'h0);
        chk("bad_addr_full", 32'(bus.fifo_full), 32'h0);
        bus.detect_add = 1'b1;
        bus.data_in    = 2'd2;
        step();
        bus.detect_add = 1'b0;
        chk("addr2_err_clr", 32'(bus.addr_err), 32'h0);
        chk("addr2_we", 32'(bus.write_enb), 32'h4);
        chk("addr2_full", 32'(bus.fifo_full), 32'h1);
        bus.write_enb_reg = 1'b0;
        bus.full          = 3'b000;
        bus.empty         = 3'b010;
        #1;
        chk("vld_out_pattern", 32'(bus.vld_out), 32'h5);
        chk("we_idle", 32'(bus.write_enb), 32'h0);

        // Channel 0 held valid and unread.
        bus.empty = 3'b110;
        quiet(29, "to_quiet_first");
        step();
        chk("to_pulse_first", 32'(bus.soft_reset), 32'h1);
        quiet(29, "to_quiet_second");
        step();
        chk("to_pulse_second", 32'(bus.soft_reset), 32'h1);
        bus.empty = 3'b111;
        step();
        chk("to_pulse_drop", 32'(bus.soft_reset), 32'h0);

        // Read in the terminal cycle suppresses the pulse and restarts the window.
        bus.empty = 3'b110;
        quiet(29, "rd_quiet_pre");
        bus.read_enb = 3'b001;
        step();
        chk("rd_suppress", 32'(bus.soft_reset), 32'h0);
        bus.read_enb = 3'b000;
        quiet(29, "rd_quiet_post");
        step();
        chk("rd_pulse_after", 32'(bus.soft_reset), 32'h1);
        bus.empty = 3'b111;
        step();

        // Asynchronous reset in the middle of a count.
        bus.detect_add = 1'b1;
        bus.data_in    = 2'd3;
        step();
        bus.detect_add    = 1'b0;
        bus.write_enb_reg = 1'b1;
        chk("pre_rst_addr_err", 32'(bus.addr_err), 32'h1);
        bus.empty = 3'b110;
        quiet(20, "pre_rst_count");
        #2;
        resetn = 1'b0;
        #1;
        chk("async_addr_err", 32'(bus.addr_err), 32'h0);
        chk("async_addr_sel0", 32'(bus.write_enb), 32'h1);
        chk("async_soft_reset", 32'(bus.soft_reset), 32'h0);
        step();
        resetn = 1'b1;
        bus.write_enb_reg = 1'b0;
        quiet(29, "post_rst_quiet");
        step();
        chk("post_rst_pulse", 32'(bus.soft_reset), 32'h1);
        bus.empty = 3'b111;
        step();

        // Channels 0 and 2 stall together while channel 1 keeps reading.
        bus.empty    = 3'b000;
        bus.read_enb = 3'b010;
        quiet(29, "multi_quiet");
        step();
        chk("multi_pulse", 32'(bus.soft_reset), 32'h5);
        bus.empty    = 3'b111;
        bus.read_enb = 3'b000;
        step();
        chk("multi_drop", 32'(bus.soft_reset), 32'h0);

`ifdef ROUTER_SYNC_STATUS_EN
        bus.sts_clr = 1'b1;
        step();
        bus.sts_clr = 1'b0;
        chk("sts_cleared", 32'(bus.timeout_sts), 32'h0);
        bus.empty = 3'b011;
        quiet(29, "sts_quiet");
        step();
        chk("sts_pulse_ch2", 32'(bus.soft_reset), 32'h4);
        chk("sts_set_ch2", 32'(bus.timeout_sts), 32'h4);
        bus.empty = 3'b111;
        step();
        step();
        chk("sts_sticky", 32'(bus.timeout_sts), 32'h4);
        bus.sts_clr = 1'b1;
        step();
        bus.sts_clr = 1'b0;
        chk("sts_clr", 32'(bus.timeout_sts), 32'h0);
        bus.empty = 3'b011;
        quiet(29, "sts_quiet_coinc");
        bus.sts_clr = 1'b1;
        step();
        chk("sts_set_wins", 32'(bus.timeout_sts), 32'h4);
        step();
        chk("sts_clr_after", 32'(bus.timeout_sts), 32'h0);
        bus.sts_clr = 1'b0;
        bus.empty   = 3'b111;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
